// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and helpers for the memory-port controller and its byte sequencer.
package mem_port_ctrl_pkg;

  localparam int MC_DW = 32;

  // Controller state: IDLE accepts requests, STORE is mirroring a store byte by byte.
  typedef enum logic {
    MC_IDLE  = 1'b0,
    MC_STORE = 1'b1
  } mc_state_t;

  // Which issue lane owns the store in flight (selects the sdone pulse).
  typedef enum logic {
    LANE_1 = 1'b0,
    LANE_2 = 1'b1
  } mc_lane_t;

  // Isolate the lowest set bit of a byte-enable mask (zero in, zero out).
  function automatic logic [3:0] low_bit(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-beat sequencer: walks a store's byte enables lowest byte first.
// rem holds the bytes still to issue after the beat currently on the ports,
// so beat is the next beat to present and last means the current one is final.
module mem_byte_seq
  import mem_port_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] mask,
  input  logic       advance,
  output logic [3:0] beat,
  output logic       last
);

  logic [3:0] rem;

  // Load strips the first beat (issued directly by the controller); advance strips the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= 4'd0;
    end else if (load) begin
      rem <= mask & ~low_bit(mask);
    end else if (advance) begin
      rem <= rem & ~low_bit(rem);
    end
  end

  assign beat = low_bit(rem);
  assign last = (rem == 4'd0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-stage port controller: parallel loads on two ports, stores mirrored to
// both port copies as one-byte beats, lane 1 treated as the older instruction.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int DW = MC_DW,
  parameter int AW = 8
) (
  input  logic          mc_clk,
  input  logic          mc_rst,
  input  logic          mc_i_valid_1,
  input  logic          mc_i_valid_2,
  input  logic          mc_i_we_1,
  input  logic          mc_i_we_2,
  input  logic [3:0]    mc_i_mask_1,
  input  logic [3:0]    mc_i_mask_2,
  input  logic [AW-1:0] mc_i_addr_1,
  input  logic [AW-1:0] mc_i_addr_2,
  input  logic [DW-1:0] mc_i_wdata_1,
  input  logic [DW-1:0] mc_i_wdata_2,
  output logic          mc_o_ready_1,
  output logic          mc_o_ready_2,
  output logic          mc_o_rvalid_1,
  output logic          mc_o_rvalid_2,
  output logic [DW-1:0] mc_o_rdata_1,
  output logic [DW-1:0] mc_o_rdata_2,
  output logic          mc_o_sdone_1,
  output logic          mc_o_sdone_2,
  output logic          mc_o_ce_1,
  output logic          mc_o_ce_2,
  output logic          mc_o_wr_en_1,
  output logic          mc_o_wr_en_2,
  output logic [3:0]    mc_o_mask_1,
  output logic [3:0]    mc_o_mask_2,
  output logic [AW-1:0] mc_o_addr_1,
  output logic [AW-1:0] mc_o_addr_2,
  output logic [DW-1:0] mc_o_wdata_1,
  output logic [DW-1:0] mc_o_wdata_2,
  input  logic [DW-1:0] mc_i_load_data_1,
  input  logic [DW-1:0] mc_i_load_data_2
);

  mc_state_t     state;
  mc_lane_t      owner;
  logic          ld_vld_1_p0;
  logic          ld_vld_2_p0;

  logic          in_idle;
  logic          acc_1;
  logic          acc_2;
  logic          st_1;
  logic          st_2;
  logic          ld_1;
  logic          ld_2;
  logic          st_acc;
  logic [3:0]    st_mask;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic [3:0]    seq_beat;
  logic          seq_last;
  logic          seq_adv;

  // Lane 2 may only go alongside lane 1 when both are loads; a lane-1 store, or a
  // lane-2 store behind a lane-1 load, must wait so program order is preserved.
  assign in_idle      = (state == MC_IDLE) && !mc_rst;
  assign mc_o_ready_1 = in_idle;
  assign mc_o_ready_2 = in_idle && (!mc_i_valid_1 || (!mc_i_we_1 && !mc_i_we_2));

  assign acc_1 = mc_i_valid_1 && mc_o_ready_1;
  assign acc_2 = mc_i_valid_2 && mc_o_ready_2;
  assign st_1  = acc_1 && mc_i_we_1;
  assign st_2  = acc_2 && mc_i_we_2;
  assign ld_1  = acc_1 && !mc_i_we_1;
  assign ld_2  = acc_2 && !mc_i_we_2;

  // At most one store is accepted per cycle, and never together with a load.
  assign st_acc   = st_1 || st_2;
  assign st_mask  = st_1 ? mc_i_mask_1  : mc_i_mask_2;
  assign st_addr  = st_1 ? mc_i_addr_1  : mc_i_addr_2;
  assign st_wdata = st_1 ? mc_i_wdata_1 : mc_i_wdata_2;

  assign seq_adv = (state == MC_STORE) && !seq_last;

  mem_byte_seq u_seq (
    .clk     (mc_clk),
    .rst     (mc_rst),
    .load    (st_acc),
    .mask    (st_mask),
    .advance (seq_adv),
    .beat    (seq_beat),
    .last    (seq_last)
  );

  // Controller FSM with registered memory-port outputs and store-complete pulses.
  always_ff @(posedge mc_clk) begin
    if (mc_rst) begin
      state        <= MC_IDLE;
      owner        <= LANE_1;
      mc_o_ce_1    <= 1'b0;
      mc_o_ce_2    <= 1'b0;
      mc_o_wr_en_1 <= 1'b0;
      mc_o_wr_en_2 <= 1'b0;
      mc_o_mask_1  <= 4'd0;
      mc_o_mask_2  <= 4'd0;
      mc_o_addr_1  <= '0;
      mc_o_addr_2  <= '0;
      mc_o_wdata_1 <= '0;
      mc_o_wdata_2 <= '0;
      mc_o_sdone_1 <= 1'b0;
      mc_o_sdone_2 <= 1'b0;
      ld_vld_1_p0  <= 1'b0;
      ld_vld_2_p0  <= 1'b0;
    end else begin
      mc_o_sdone_1 <= 1'b0;
      mc_o_sdone_2 <= 1'b0;
      ld_vld_1_p0  <= 1'b0;
      ld_vld_2_p0  <= 1'b0;
      case (state)
        MC_IDLE: begin
          mc_o_ce_1    <= 1'b0;
          mc_o_ce_2    <= 1'b0;
          mc_o_wr_en_1 <= 1'b0;
          mc_o_wr_en_2 <= 1'b0;
          mc_o_mask_1  <= 4'd0;
          mc_o_mask_2  <= 4'd0;
          mc_o_addr_1  <= '0;
          mc_o_addr_2  <= '0;
          mc_o_wdata_1 <= '0;
          mc_o_wdata_2 <= '0;
          if (st_acc) begin
            owner <= st_1 ? LANE_1 : LANE_2;
            if (st_mask != 4'd0) begin
              // First beat goes out immediately on both copies.
              state        <= MC_STORE;
              mc_o_ce_1    <= 1'b1;
              mc_o_ce_2    <= 1'b1;
              mc_o_wr_en_1 <= 1'b1;
              mc_o_wr_en_2 <= 1'b1;
              mc_o_mask_1  <= low_bit(st_mask);
              mc_o_mask_2  <= low_bit(st_mask);
              mc_o_addr_1  <= st_addr;
              mc_o_addr_2  <= st_addr;
              mc_o_wdata_1 <= st_wdata;
              mc_o_wdata_2 <= st_wdata;
            end else begin
              // Nothing to write: complete right away.
              mc_o_sdone_1 <= st_1;
              mc_o_sdone_2 <= st_2;
            end
          end else begin
            if (ld_1) begin
              mc_o_ce_1   <= 1'b1;
              mc_o_addr_1 <= mc_i_addr_1;
              ld_vld_1_p0 <= 1'b1;
            end
            if (ld_2) begin
              mc_o_ce_2   <= 1'b1;
              mc_o_addr_2 <= mc_i_addr_2;
              ld_vld_2_p0 <= 1'b1;
            end
          end
        end
        MC_STORE: begin
          if (seq_last) begin
            state        <= MC_IDLE;
            mc_o_ce_1    <= 1'b0;
            mc_o_ce_2    <= 1'b0;
            mc_o_wr_en_1 <= 1'b0;
            mc_o_wr_en_2 <= 1'b0;
            mc_o_mask_1  <= 4'd0;
            mc_o_mask_2  <= 4'd0;
            mc_o_addr_1  <= '0;
            mc_o_addr_2  <= '0;
            mc_o_wdata_1 <= '0;
            mc_o_wdata_2 <= '0;
            mc_o_sdone_1 <= (owner == LANE_1);
            mc_o_sdone_2 <= (owner == LANE_2);
          end else begin
            mc_o_mask_1 <= seq_beat;
            mc_o_mask_2 <= seq_beat;
          end
        end
      endcase
    end
  end

  // ---- stage p0 -> response: capture memory read data one cycle after issue ----
  always_ff @(posedge mc_clk) begin
    if (mc_rst) begin
      mc_o_rvalid_1 <= 1'b0;
      mc_o_rvalid_2 <= 1'b0;
      mc_o_rdata_1  <= '0;
      mc_o_rdata_2  <= '0;
    end else begin
      mc_o_rvalid_1 <= ld_vld_1_p0;
      mc_o_rvalid_2 <= ld_vld_2_p0;
      if (ld_vld_1_p0) mc_o_rdata_1 <= mc_i_load_data_1;
      if (ld_vld_2_p0) mc_o_rdata_2 <= mc_i_load_data_2;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: dual-copy memory model, directed scenarios and
// randomized lane pairs checked against a word-level reference memory.
module tb_mem_port_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NW   = 16;
  localparam int LOGN = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_1, valid_2, we_1, we_2;
  logic [3:0]    imask_1, imask_2;
  logic [AW-1:0] iaddr_1, iaddr_2;
  logic [DW-1:0] iwdata_1, iwdata_2;
  logic          ready_1, ready_2, rvalid_1, rvalid_2, sdone_1, sdone_2;
  logic [DW-1:0] rdata_1, rdata_2;
  logic          ce_1, ce_2, wr_en_1, wr_en_2;
  logic [3:0]    mask_1, mask_2;
  logic [AW-1:0] addr_1, addr_2;
  logic [DW-1:0] wdata_1, wdata_2;
  logic [DW-1:0] load_data_1, load_data_2;

  always #5 clk = ~clk;

  mem_port_ctrl #(.DW(DW), .AW(AW)) dut (
    .mc_clk(clk), .mc_rst(rst),
    .mc_i_valid_1(valid_1), .mc_i_valid_2(valid_2),
    .mc_i_we_1(we_1), .mc_i_we_2(we_2),
    .mc_i_mask_1(imask_1), .mc_i_mask_2(imask_2),
    .mc_i_addr_1(iaddr_1), .mc_i_addr_2(iaddr_2),
    .mc_i_wdata_1(iwdata_1), .mc_i_wdata_2(iwdata_2),
    .mc_o_ready_1(ready_1), .mc_o_ready_2(ready_2),
    .mc_o_rvalid_1(rvalid_1), .mc_o_rvalid_2(rvalid_2),
    .mc_o_rdata_1(rdata_1), .mc_o_rdata_2(rdata_2),
    .mc_o_sdone_1(sdone_1), .mc_o_sdone_2(sdone_2),
    .mc_o_ce_1(ce_1), .mc_o_ce_2(ce_2),
    .mc_o_wr_en_1(wr_en_1), .mc_o_wr_en_2(wr_en_2),
    .mc_o_mask_1(mask_1), .mc_o_mask_2(mask_2),
    .mc_o_addr_1(addr_1), .mc_o_addr_2(addr_2),
    .mc_o_wdata_1(wdata_1), .mc_o_wdata_2(wdata_2),
    .mc_i_load_data_1(load_data_1), .mc_i_load_data_2(load_data_2)
  );

  // Two private memory copies; byte writes land on the falling edge.
  logic [DW-1:0] mem1 [NW];
  logic [DW-1:0] mem2 [NW];
  logic          mem_init;

  always @(negedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < NW; w++) begin
        mem1[w] <= DW'(w);
        mem2[w] <= DW'(w);
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ce_1 && wr_en_1 && mask_1[b]) mem1[addr_1][8*b +: 8] <= wdata_1[8*b +: 8];
        if (ce_2 && wr_en_2 && mask_2[b]) mem2[addr_2][8*b +: 8] <= wdata_2[8*b +: 8];
      end
    end
  end

  assign load_data_1 = mem1[addr_1];
  assign load_data_2 = mem2[addr_2];

  // Reference: what memory should contain after each completed operation.
  logic [DW-1:0] ref_mem [NW];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rdy1, rdy2, hs1, hs2, ce1, ce2, we1, we2, rv1, rv2, sd1, sd2;
    logic [3:0] m1, m2;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] wd1, wd2, rd1, rd2;
  } cyc_t;

  cyc_t lg [LOGN];

  task automatic apply_store(input logic [AW-1:0] a, input logic [3:0] m, input logic [DW-1:0] d);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // k-th enabled byte (counting from byte 0) as a one-hot beat.
  function automatic logic [3:0] beats_of(input logic [3:0] m, input int k);
    int n = 0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        if (n == k) return 4'(1 << b);
        n++;
      end
    end
    return 4'd0;
  endfunction

  // Sample outputs mid-cycle for n cycles; drop a lane's valid once it is accepted.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lg[i].rdy1 = ready_1;  lg[i].rdy2 = ready_2;
      lg[i].hs1  = valid_1 && ready_1;
      lg[i].hs2  = valid_2 && ready_2;
      lg[i].ce1  = ce_1;     lg[i].ce2  = ce_2;
      lg[i].we1  = wr_en_1;  lg[i].we2  = wr_en_2;
      lg[i].m1   = mask_1;   lg[i].m2   = mask_2;
      lg[i].a1   = addr_1;   lg[i].a2   = addr_2;
      lg[i].wd1  = wdata_1;  lg[i].wd2  = wdata_2;
      lg[i].rv1  = rvalid_1; lg[i].rv2  = rvalid_2;
      lg[i].rd1  = rdata_1;  lg[i].rd2  = rdata_2;
      lg[i].sd1  = sdone_1;  lg[i].sd2  = sdone_2;
      @(posedge clk);
      #1;
      if (lg[i].hs1) valid_1 = 1'b0;
      if (lg[i].hs2) valid_2 = 1'b0;
    end
  endtask

  task automatic drive(input int lane, input logic we, input logic [3:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (lane == 1) begin
      valid_1 = 1'b1; we_1 = we; imask_1 = m; iaddr_1 = a; iwdata_1 = d;
    end else begin
      valid_2 = 1'b1; we_2 = we; imask_2 = m; iaddr_2 = a; iwdata_2 = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready_1, ready_2} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {ready_1, ready_2});
    end
    checks++;
    if ({ce_1, wr_en_1, mask_1, addr_1, wdata_1} !== '0) begin
      errors++; $display("FAIL reset_port1 got %h want 0", {ce_1, wr_en_1, mask_1, addr_1, wdata_1});
    end
    checks++;
    if ({ce_2, wr_en_2, mask_2, addr_2, wdata_2} !== '0) begin
      errors++; $display("FAIL reset_port2 got %h want 0", {ce_2, wr_en_2, mask_2, addr_2, wdata_2});
    end
    checks++;
    if ({rvalid_1, rvalid_2, sdone_1, sdone_2, rdata_1, rdata_2} !== '0) begin
      errors++; $display("FAIL reset_resp got %h want 0", {rvalid_1, rvalid_2, sdone_1, sdone_2, rdata_1, rdata_2});
    end
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_1, ready_2} !== 2'b11) begin
      errors++; $display("FAIL idle_ready got %b want 11", {ready_1, ready_2});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_dual_load();
    drive(1, 1'b0, 4'h0, 4'd3, '0);
    drive(2, 1'b0, 4'h0, 4'd5, '0);
    run(4);
    checks++;
    if ({lg[0].hs1, lg[0].hs2} !== 2'b11) begin
      errors++; $display("FAIL dual_accept got %b want 11", {lg[0].hs1, lg[0].hs2});
    end
    checks++;
    if ({lg[1].ce1, lg[1].we1, lg[1].a1, lg[1].ce2, lg[1].we2, lg[1].a2} !== {2'b10, 4'd3, 2'b10, 4'd5}) begin
      errors++; $display("FAIL dual_ports got %h want %h",
        {lg[1].ce1, lg[1].we1, lg[1].a1, lg[1].ce2, lg[1].we2, lg[1].a2}, {2'b10, 4'd3, 2'b10, 4'd5});
    end
    checks++;
    if ({lg[2].rv1, lg[2].rv2, lg[3].rv1, lg[3].rv2} !== 4'b1100) begin
      errors++; $display("FAIL dual_rvalid got %b want 1100", {lg[2].rv1, lg[2].rv2, lg[3].rv1, lg[3].rv2});
    end
    checks++;
    if ({lg[2].rd1, lg[2].rd2} !== {ref_mem[3], ref_mem[5]}) begin
      errors++; $display("FAIL dual_rdata got %h want %h", {lg[2].rd1, lg[2].rd2}, {ref_mem[3], ref_mem[5]});
    end
  endtask

  task automatic test_store_full();
    int sd1n, sd2n;
    logic [3:0] e;
    drive(1, 1'b1, 4'hF, 4'd2, 32'hAABBCCDD);
    run(8);
    apply_store(4'd2, 4'hF, 32'hAABBCCDD);
    for (int i = 1; i <= 4; i++) begin
      e = beats_of(4'hF, i - 1);
      checks++;
      if ({lg[i].ce1, lg[i].we1, lg[i].ce2, lg[i].we2, lg[i].m1, lg[i].m2, lg[i].a1, lg[i].a2,
           lg[i].wd1, lg[i].wd2, lg[i].rdy1, lg[i].rdy2} !==
          {4'hF, e, e, 4'd2, 4'd2, 32'hAABBCCDD, 32'hAABBCCDD, 2'b00}) begin
        errors++; $display("FAIL store_beat%0d got ce/we=%b%b%b%b m=%b/%b a=%0d wd=%h rdy=%b%b want mask %b",
          i, lg[i].ce1, lg[i].we1, lg[i].ce2, lg[i].we2, lg[i].m1, lg[i].m2, lg[i].a1, lg[i].wd1,
          lg[i].rdy1, lg[i].rdy2, e);
      end
    end
    sd1n = 0; sd2n = 0;
    for (int i = 0; i < 8; i++) begin
      sd1n += int'(lg[i].sd1);
      sd2n += int'(lg[i].sd2);
    end
    checks++;
    if ({lg[5].sd1, lg[5].ce1, 8'(sd1n), 8'(sd2n)} !== {2'b10, 8'd1, 8'd0}) begin
      errors++; $display("FAIL store_sdone got sd@5=%b ce@5=%b n1=%0d n2=%0d want 1 0 1 0",
        lg[5].sd1, lg[5].ce1, sd1n, sd2n);
    end
    drive(2, 1'b0, 4'h0, 4'd2, '0);
    run(3);
    checks++;
    if ({lg[2].rv2, lg[2].rd2} !== {1'b1, ref_mem[2]}) begin
      errors++; $display("FAIL store_readback got %b %h want 1 %h", lg[2].rv2, lg[2].rd2, ref_mem[2]);
    end
  endtask

  task automatic test_two_stores();
    int n1, n2, j;
    n1 = $countones(4'b0101);
    n2 = $countones(4'b1000);
    drive(1, 1'b1, 4'b0101, 4'd4, 32'h11223344);
    drive(2, 1'b1, 4'b1000, 4'd4, 32'h99000000);
    run(10);
    apply_store(4'd4, 4'b0101, 32'h11223344);
    apply_store(4'd4, 4'b1000, 32'h99000000);
    checks++;
    if ({lg[0].hs1, lg[0].hs2} !== 2'b10) begin
      errors++; $display("FAIL two_st_accept got %b want 10", {lg[0].hs1, lg[0].hs2});
    end
    for (int i = 0; i < n1; i++) begin
      checks++;
      if ({lg[i+1].we1, lg[i+1].we2, lg[i+1].m1, lg[i+1].m2, lg[i+1].wd1} !==
          {2'b11, beats_of(4'b0101, i), beats_of(4'b0101, i), 32'h11223344}) begin
        errors++; $display("FAIL two_st_l1_beat%0d got m=%b/%b wd=%h want %b", i,
          lg[i+1].m1, lg[i+1].m2, lg[i+1].wd1, beats_of(4'b0101, i));
      end
    end
    checks++;
    if ({lg[n1+1].sd1, lg[n1+1].sd2, lg[n1+1].ce1, lg[n1+1].hs2} !== 4'b1001) begin
      errors++; $display("FAIL two_st_handover got sd=%b%b ce=%b hs2=%b want 10 0 1",
        lg[n1+1].sd1, lg[n1+1].sd2, lg[n1+1].ce1, lg[n1+1].hs2);
    end
    for (int i = 0; i < n2; i++) begin
      j = n1 + 2 + i;
      checks++;
      if ({lg[j].we1, lg[j].we2, lg[j].m1, lg[j].m2, lg[j].wd2} !==
          {2'b11, beats_of(4'b1000, i), beats_of(4'b1000, i), 32'h99000000}) begin
        errors++; $display("FAIL two_st_l2_beat%0d got m=%b/%b wd=%h want %b", i,
          lg[j].m1, lg[j].m2, lg[j].wd2, beats_of(4'b1000, i));
      end
    end
    j = n1 + n2 + 2;
    checks++;
    if ({lg[j].sd1, lg[j].sd2} !== 2'b01) begin
      errors++; $display("FAIL two_st_sdone2 got %b want 01", {lg[j].sd1, lg[j].sd2});
    end
    drive(1, 1'b0, 4'h0, 4'd4, '0);
    drive(2, 1'b0, 4'h0, 4'd4, '0);
    run(3);
    checks++;
    if ({lg[2].rd1, lg[2].rd2} !== {ref_mem[4], ref_mem[4]} || ref_mem[4] !== 32'h99220044) begin
      errors++; $display("FAIL two_st_readback got %h %h want %h", lg[2].rd1, lg[2].rd2, 32'h99220044);
    end
  endtask

  task automatic test_load_then_store();
    logic [DW-1:0] old;
    old = ref_mem[7];
    drive(1, 1'b0, 4'h0, 4'd7, '0);
    drive(2, 1'b1, 4'b0001, 4'd7, 32'h000000FF);
    run(6);
    apply_store(4'd7, 4'b0001, 32'h000000FF);
    checks++;
    if ({lg[0].hs1, lg[0].rdy2, lg[1].ce1, lg[1].we1, lg[1].a1, lg[1].hs2} !== {4'b1010, 4'd7, 1'b1}) begin
      errors++; $display("FAIL ld_st_order got hs1=%b rdy2=%b ce=%b we=%b a=%0d hs2=%b",
        lg[0].hs1, lg[0].rdy2, lg[1].ce1, lg[1].we1, lg[1].a1, lg[1].hs2);
    end
    checks++;
    if ({lg[2].rv1, lg[2].rd1} !== {1'b1, old}) begin
      errors++; $display("FAIL ld_st_oldval got %b %h want 1 %h", lg[2].rv1, lg[2].rd1, old);
    end
    checks++;
    if ({lg[2].we1, lg[2].we2, lg[2].m1, lg[2].m2, lg[3].sd2, lg[3].sd1, lg[3].ce1} !== 13'b11_0001_0001_100) begin
      errors++; $display("FAIL ld_st_beat got we=%b%b m=%b/%b sd2=%b sd1=%b ce=%b",
        lg[2].we1, lg[2].we2, lg[2].m1, lg[2].m2, lg[3].sd2, lg[3].sd1, lg[3].ce1);
    end
    drive(1, 1'b0, 4'h0, 4'd7, '0);
    run(3);
    checks++;
    if (lg[2].rd1 !== ref_mem[7] || ref_mem[7] !== 32'h000000FF) begin
      errors++; $display("FAIL ld_st_newval got %h want %h", lg[2].rd1, 32'h000000FF);
    end
  endtask

  task automatic test_zero_mask();
    int cen, sdn;
    drive(1, 1'b1, 4'h0, 4'd9, 32'h12345678);
    run(4);
    cen = 0; sdn = 0;
    for (int i = 0; i < 4; i++) begin
      cen += int'(lg[i].ce1 || lg[i].ce2 || lg[i].we1 || lg[i].we2);
      sdn += int'(lg[i].sd1);
    end
    checks++;
    if ({lg[0].hs1, lg[1].sd1, 8'(cen), 8'(sdn)} !== {2'b11, 8'd0, 8'd1}) begin
      errors++; $display("FAIL zero_mask got hs=%b sd@1=%b beats=%0d sdones=%0d want 1 1 0 1",
        lg[0].hs1, lg[1].sd1, cen, sdn);
    end
    drive(2, 1'b0, 4'h0, 4'd9, '0);
    run(3);
    checks++;
    if (lg[2].rd2 !== ref_mem[9]) begin
      errors++; $display("FAIL zero_mask_read got %h want %h", lg[2].rd2, ref_mem[9]);
    end
  endtask

  task automatic test_reset_mid_store();
    int sdn;
    drive(1, 1'b1, 4'hF, 4'd6, 32'hDEADBEEF);
    @(negedge clk);
    @(posedge clk); #1 valid_1 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ce_1, wr_en_1, mask_1} !== {2'b11, beats_of(4'hF, 1)}) begin
      errors++; $display("FAIL rst_mid_beat2 got %b%b %b want 11 %b", ce_1, wr_en_1, mask_1, beats_of(4'hF, 1));
    end
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ce_1, ce_2, wr_en_1, wr_en_2, mask_1, mask_2, sdone_1, ready_1, ready_2} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got ce=%b%b we=%b%b m=%b/%b sd=%b rdy=%b%b want all 0",
        ce_1, ce_2, wr_en_1, wr_en_2, mask_1, mask_2, sdone_1, ready_1, ready_2);
    end
    @(posedge clk); #1 rst = 1'b0;
    apply_store(4'd6, 4'b0011, 32'hDEADBEEF);
    run(4);
    sdn = 0;
    for (int i = 0; i < 4; i++) sdn += int'(lg[i].sd1 || lg[i].sd2 || lg[i].ce1);
    checks++;
    if ({lg[0].rdy1, 8'(sdn)} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL rst_mid_idle got rdy=%b activity=%0d want 1 0", lg[0].rdy1, sdn);
    end
    drive(1, 1'b0, 4'h0, 4'd6, '0);
    run(3);
    checks++;
    if (lg[2].rd1 !== ref_mem[6] || ref_mem[6] !== 32'h0000BEEF) begin
      errors++; $display("FAIL rst_mid_read got %h want %h", lg[2].rd1, 32'h0000BEEF);
    end
  endtask

  task automatic test_random();
    logic v1, v2, w1, w2;
    logic [3:0] m1, m2;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d1, d2, e1, e2, rd1, rd2;
    int hs1n, hs2n, rv1n, rv2n, sd1n, sd2n, beats, bad;
    for (int t = 0; t < 40; t++) begin
      v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1));
      if (!v1 && !v2) v2 = 1'b1;
      w1 = 1'($urandom_range(0, 1)); w2 = 1'($urandom_range(0, 1));
      m1 = 4'($urandom_range(0, 15)); m2 = 4'($urandom_range(0, 15));
      a1 = AW'($urandom_range(0, NW - 1)); a2 = AW'($urandom_range(0, NW - 1));
      d1 = $urandom; d2 = $urandom;
      // Lane 1 is older: its effect is applied first.
      e1 = ref_mem[a1];
      if (v1 && w1) apply_store(a1, m1, d1);
      e2 = ref_mem[a2];
      if (v2 && w2) apply_store(a2, m2, d2);
      if (v1) drive(1, w1, m1, a1, d1);
      if (v2) drive(2, w2, m2, a2, d2);
      run(14);
      valid_1 = 1'b0; valid_2 = 1'b0;
      hs1n = 0; hs2n = 0; rv1n = 0; rv2n = 0; sd1n = 0; sd2n = 0; beats = 0; bad = 0;
      rd1 = '0; rd2 = '0;
      for (int i = 0; i < 14; i++) begin
        hs1n += int'(lg[i].hs1); hs2n += int'(lg[i].hs2);
        sd1n += int'(lg[i].sd1); sd2n += int'(lg[i].sd2);
        if (lg[i].rv1) begin rv1n++; rd1 = lg[i].rd1; end
        if (lg[i].rv2) begin rv2n++; rd2 = lg[i].rd2; end
        if (lg[i].ce1 && lg[i].we1) begin
          beats++;
          if (!$onehot(lg[i].m1) || lg[i].rdy1 || lg[i].rdy2 ||
              {lg[i].ce2, lg[i].we2, lg[i].m2, lg[i].a2, lg[i].wd2} !==
              {2'b11, lg[i].m1, lg[i].a1, lg[i].wd1}) bad++;
        end
      end
      checks++;
      if ({hs1n, hs2n} !== {int'(v1), int'(v2)}) begin
        errors++; $display("FAIL rnd%0d_accept got %0d %0d want %0d %0d", t, hs1n, hs2n, v1, v2);
      end
      checks++;
      if ({rv1n, rv2n} !== {int'(v1 && !w1), int'(v2 && !w2)}) begin
        errors++; $display("FAIL rnd%0d_rvalid got %0d %0d want %0d %0d", t, rv1n, rv2n, v1 && !w1, v2 && !w2);
      end
      if (v1 && !w1) begin
        checks++;
        if (rd1 !== e1) begin
          errors++; $display("FAIL rnd%0d_rdata1 got %h want %h", t, rd1, e1);
        end
      end
      if (v2 && !w2) begin
        checks++;
        if (rd2 !== e2) begin
          errors++; $display("FAIL rnd%0d_rdata2 got %h want %h", t, rd2, e2);
        end
      end
      checks++;
      if ({sd1n, sd2n} !== {int'(v1 && w1), int'(v2 && w2)}) begin
        errors++; $display("FAIL rnd%0d_sdone got %0d %0d want %0d %0d", t, sd1n, sd2n, v1 && w1, v2 && w2);
      end
      checks++;
      if (beats !== ((v1 && w1) ? $countones(m1) : 0) + ((v2 && w2) ? $countones(m2) : 0)) begin
        errors++; $display("FAIL rnd%0d_beats got %0d want %0d", t, beats,
          ((v1 && w1) ? $countones(m1) : 0) + ((v2 && w2) ? $countones(m2) : 0));
      end
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL rnd%0d_beat_shape got %0d bad beats want 0", t, bad);
      end
    end
    for (int w = 0; w < NW; w++) begin
      checks++;
      if (mem1[w] !== ref_mem[w] || mem2[w] !== ref_mem[w]) begin
        errors++; $display("FAIL mem_word%0d got %h/%h want %h", w, mem1[w], mem2[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    valid_1 = 1'b0; valid_2 = 1'b0; we_1 = 1'b0; we_2 = 1'b0;
    imask_1 = '0; imask_2 = '0; iaddr_1 = '0; iaddr_2 = '0; iwdata_1 = '0; iwdata_2 = '0;
    for (int w = 0; w < NW; w++) ref_mem[w] = DW'(w);
    test_reset();
    test_dual_load();
    test_store_full();
    test_two_stores();
    test_load_then_store();
    test_zero_mask();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Controller between the two memory-stage issue lanes and the dual-port data memory.
- The data memory keeps a private copy of the array per port and writes one byte lane per write beat.
- This block mirrors every store to both copies as a sequence of one-byte beats, and lets loads from both lanes proceed in parallel when no store is in flight.
- It also orders the lanes (lane 1 older) and returns load data with fixed latency.

Parameters:
- DW, `DWIDTH (32): data width, must be 32 (four byte lanes).
- AW, `AWIDTH_MEM: word-address width.

Ports:
- mc_clk  in  1  clock; all state updates on the rising edge.
- mc_rst  in  1  reset, synchronous, active-high.
- mc_i_valid_1 / mc_i_valid_2  in  1  lane request valid.
- mc_i_we_1 / mc_i_we_2  in  1  1 = store, 0 = load.
- mc_i_mask_1 / mc_i_mask_2  in  4  store byte enables; ignored for loads.
- mc_i_addr_1 / mc_i_addr_2  in  AW  word address.
- mc_i_wdata_1 / mc_i_wdata_2  in  DW  store data.
- mc_o_ready_1 / mc_o_ready_2  out  1  request accepted when valid&ready at a rising edge.
- mc_o_rvalid_1 / mc_o_rvalid_2  out  1  one-cycle load-data-valid pulse.
- mc_o_rdata_1 / mc_o_rdata_2  out  DW  registered load data.
- mc_o_sdone_1 / mc_o_sdone_2  out  1  one-cycle store-complete pulse.
- mc_o_ce_1/2, mc_o_wr_en_1/2  out  1  memory port controls.
- mc_o_mask_1/2  out  4  one-hot byte beat.
- mc_o_addr_1/2  out  AW  memory port address.
- mc_o_wdata_1/2  out  DW  memory port write data.
- mc_i_load_data_1/2  in  DW  memory read data (combinational from mc_o_addr_x).

Behaviour:
- Reset values: all memory-port outputs are registered and 0. rvalid, sdone, rdata are 0; ready is 0 during reset; state is IDLE.
- States:
  - IDLE: ready_1 = 1. ready_2 = 1 only when lane 1 cannot block it (rules below).
  - STORE: both readies = 0.
  - RESP: internal to the load path, no stall.
- Acceptance in IDLE, same cycle:
  - Both loads: accept both. Port 1 serves lane 1, port 2 serves lane 2.
  - Lane 1 store: accept lane 1 only; lane 2 waits.
  - Lane 1 load and lane 2 store: accept lane 1 only. The store is accepted the next IDLE cycle, after the load has been issued.
  - Lane 1 not valid: lane 2 is accepted alone, on port 2 for a load.
- Load timing, handshake at edge k:
  - Port driven from edge k with ce = 1, wr_en = 0, addr.
  - At edge k+1, load_data is captured into rdata and rvalid pulses for one cycle.
  - Back-to-back loads sustain one per lane per cycle.
- Store timing, handshake at edge k, nonzero mask:
  - Remaining-mask register ← mask; enter STORE.
  - Each cycle from edge k, issue one beat on BOTH ports: ce = 1, wr_en = 1, same addr and wdata, mask = lowest set bit of the remaining mask.
  - Clear that bit at the next edge.
  - Beats = popcount(mask), lowest byte first.
  - sdone pulses in the cycle after the last beat's edge; return to IDLE at that edge. Ports go idle (ce = 0) unless a new request is accepted at the same edge.
- Zero-mask store: accepted, no beats, sdone pulses the cycle after the handshake.
- A store on lane 2 waiting behind lane 1 observes lane 1's completed beats.
  - A load accepted after an sdone reads the new data from either lane.
  - Memory writes land on the falling edge of each beat cycle.
- Reset asserted mid-store: at the next edge, beats stop, state → IDLE, no sdone. Bytes already written remain.
- rvalid and sdone never assert for a request that was not accepted.

Decomposition:
- Shared header.vh: `DWIDTH, `AWIDTH_MEM, and new state encodings `MC_IDLE, `MC_STORE.
- One sub-module, mem_byte_seq:
  - Holds the remaining mask.
  - Outputs the one-hot current beat and a last-beat flag.
  - Inputs: load, mask, advance.

Test Plan:
- Reset, memory initialised with word i = i. Lane 1 load addr 3, lane 2 load addr 5, same cycle → both ready; one cycle later rvalid_1 = rvalid_2 = 1, rdata_1 = 3, rdata_2 = 5.
- Lane 1 store addr 2, mask 1111, wdata 0xAABBCCDD → ports show masks 0001, 0010, 0100, 1000 on consecutive cycles on both ports, ready low throughout. sdone_1 pulses once. A following lane 2 load of addr 2 → 0xAABBCCDD.
- Lane 1 store addr 4, mask 0101, data 0x11223344, and lane 2 store addr 4, mask 1000, data 0x99000000, same cycle → lane 1 completes 2 beats, then lane 2 completes 1 beat. Load addr 4 → 0x99220044 from both lanes.
- Lane 1 load addr 7 with lane 2 store addr 7, mask 0001, data 0xFF → lane 1 returns 7 (old value), then store proceeds. Subsequent load → 0x000000FF.
- Zero-mask store at addr 9 → no ce/wr_en beat, sdone pulses next cycle. Load addr 9 → 9.
- Store mask 1111 at addr 6; assert mc_rst after the 2nd beat → no sdone, state IDLE, outputs 0. Load addr 6 → bytes 0–1 new, bytes 2–3 old.
